// File: rtl/adder_pkg.sv
// Shared types and constants for the sliced add/subtract sequencer.
// Holds the controller state encoding, default datapath sizes and the step-count helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SLICE = 8;

  function automatic int calc_steps(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// SLICE-bit carry-look-ahead adder built from per-bit generate/propagate cells.
// Also exposes the carry into its top bit so the caller can derive signed overflow.
module cla_slice
  import adder_pkg::*;
#(
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic             acc;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded independently from c_in so no carry waits on its neighbour.
  always_comb begin
    c   = '0;
    acc = 1'b0;
    c[0] = c_in;
    for (int i = 0; i < SLICE; i++) begin
      acc = c_in;
      for (int j = 0; j <= i; j++) begin
        acc = g[j] | (p[j] & acc);
      end
      c[i+1] = acc;
    end
  end

  assign s     = p ^ c[SLICE-1:0];
  assign c_out = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/adder_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that steps one narrow CLA slice across the operands,
// LSB slice first, with a registered carry between steps and valid/ready on both sides.
module adder_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int STEPS  = calc_steps(WIDTH, SLICE);
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE-1:0]   slice_s;
  logic               slice_cout;
  logic               slice_cmsb;
  logic               last_step;

  cla_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_cout),
    .c_msb (slice_cmsb)
  );

  assign last_step = (step_q == STEP_W'(STEPS - 1));

  // Subtraction is folded in at accept time: B is inverted and the carry seeded with 1.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    step_d  = step_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          step_d  = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        sum_d   = (sum_q >> SLICE) | (WIDTH'(slice_s) << (WIDTH - SLICE));
        carry_d = slice_cout;
        step_d  = step_q + STEP_W'(1);
        if (last_step) begin
          state_d = DONE;
          step_d  = '0;
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer: directed operands push expected results,
// a negedge monitor pops and compares whenever a new result is presented.
module tb_adder_sequencer;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int STEPS = WIDTH / SLICE;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  exp_t sbQueue[$];
  int   compared;
  int   mismatched;
  int   runCount;
  logic prevValid;

  adder_sequencer #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: counts RUN cycles, then scores each newly presented result.
  initial begin
    runCount  = 0;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n || !busy) begin
        runCount = 0;
      end else if (!out_valid) begin
        runCount++;
      end
      if (out_valid && !prevValid) begin
        exp_t e;
        checkOutput("latency", WIDTH'(runCount), WIDTH'(STEPS));
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("sum", sum, e.sum);
          checkOutput("cout", WIDTH'(cout), WIDTH'(e.cout));
          checkOutput("ovf", WIDTH'(ovf), WIDTH'(e.ovf));
        end
      end
      prevValid = out_valid;
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitValid();
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input logic vsub, input logic [WIDTH-1:0] esum,
                               input logic ecout, input logic eovf);
    exp_t e;
    waitReady();
    a        = va;
    b        = vb;
    sub      = vsub;
    in_valid = 1'b1;
    e.sum  = esum;
    e.cout = ecout;
    e.ovf  = eovf;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = '1;
    b        = '1;
    sub      = ~vsub;
  endtask

  task automatic runOne(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vsub, input logic [WIDTH-1:0] esum,
                        input logic ecout, input logic eovf);
    applyStimulus(va, vb, vsub, esum, ecout, eovf);
    waitValid();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    a          = '0;
    b          = '0;
    sub        = 1'b0;
    #12;
    checkOutput("rst_in_ready", WIDTH'(in_ready), 32'd1);
    checkOutput("rst_out_valid", WIDTH'(out_valid), 32'd0);
    checkOutput("rst_busy", WIDTH'(busy), 32'd0);
    checkOutput("rst_sum", sum, 32'd0);
    checkOutput("rst_cout", WIDTH'(cout), 32'd0);
    checkOutput("rst_ovf", WIDTH'(ovf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    runOne(32'd5,        32'd3,        1'b0, 32'h0000_0008, 1'b0, 1'b0);
    runOne(32'hFFFF_FFFF, 32'd1,        1'b0, 32'h0000_0000, 1'b1, 1'b0);
    runOne(32'h7FFF_FFFF, 32'd1,        1'b0, 32'h8000_0000, 1'b0, 1'b1);
    runOne(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    runOne(32'd3,        32'd5,        1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runOne(32'h8000_0000, 32'd1,        1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    runOne(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    runOne(32'd10,       32'd10,       1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // Backpressure: stall in DONE while offering operands that must be ignored.
    out_ready = 1'b0;
    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    waitValid();
    for (int i = 0; i < 3; i++) begin
      a        = 32'hDEAD_BEEF;
      b        = 32'h0BAD_F00D;
      sub      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("stall_out_valid", WIDTH'(out_valid), 32'd1);
      checkOutput("stall_in_ready", WIDTH'(in_ready), 32'd0);
      checkOutput("stall_sum", sum, 32'h8000_0000);
      checkOutput("stall_cout", WIDTH'(cout), 32'd0);
      checkOutput("stall_ovf", WIDTH'(ovf), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", WIDTH'(in_ready), 32'd1);
    checkOutput("release_out_valid", WIDTH'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("idle_busy", WIDTH'(busy), 32'd0);
    checkOutput("idle_sum_hold", sum, 32'h8000_0000);
    runOne(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Reset abort after the second RUN step; this operation never produces a result.
    waitReady();
    a        = 32'h0102_0304;
    b        = 32'h0101_0101;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", WIDTH'(out_valid), 32'd0);
    checkOutput("abort_busy", WIDTH'(busy), 32'd0);
    checkOutput("abort_in_ready", WIDTH'(in_ready), 32'd1);
    checkOutput("abort_sum", sum, 32'd0);
    checkOutput("abort_cout", WIDTH'(cout), 32'd0);
    checkOutput("abort_ovf", WIDTH'(ovf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    runOne(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", WIDTH'(sbQueue.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
